branch_stall_tracker: RTL

Parametrised front-end stall controller that tracks up to MAX_BR in-flight branches by ROB tag in a FIFO, instead of serialising on a single branch. It combines branch back-pressure with ROB-full and rename-unavailable conditions to produce fetch and decode stalls. A mispredict flush clears all tracked branches. It sits between decode/rename and the ROB commit port.

---
 rtl/branch_stall_if.sv | 39 +++
 rtl/branch_stall_tracker.sv | 91 +++++++++
 2 files changed

// File: rtl/branch_stall_if.sv
// Bundle of decode, rename, commit and stall signals shared by the
// branch stall tracker and its neighbouring pipeline stages.
interface branch_stall_if #(
  parameter int ROB_TAG_W = 5,
  parameter int MAX_BR    = 4
);
  localparam int CNT_W = $clog2(MAX_BR + 1);

  logic                 rob_full;
  logic                 cannot_rename;
  logic                 inst_valid;
  logic                 branch_op_incoming;
  logic [ROB_TAG_W-1:0] branch_op_incoming_tag;
  logic                 commit_valid;
  logic                 commited_branch_op;
  logic [ROB_TAG_W-1:0] commited_branch_tag;
  logic                 flush;
  logic                 stall_fetch;
  logic                 stall_decode;
  logic [CNT_W-1:0]     outstanding_count;
  logic [ROB_TAG_W-1:0] oldest_tag;
  logic                 tag_mismatch_err;

  modport master (
    output rob_full, cannot_rename, inst_valid, branch_op_incoming,
           branch_op_incoming_tag, commit_valid, commited_branch_op,
           commited_branch_tag, flush,
    input  stall_fetch, stall_decode, outstanding_count, oldest_tag,
           tag_mismatch_err
  );

  modport slave (
    input  rob_full, cannot_rename, inst_valid, branch_op_incoming,
           branch_op_incoming_tag, commit_valid, commited_branch_op,
           commited_branch_tag, flush,
    output stall_fetch, stall_decode, outstanding_count, oldest_tag,
           tag_mismatch_err
  );
endinterface

// File: rtl/branch_stall_tracker.sv
// Front-end stall controller tracking in-flight branches by ROB tag in a FIFO,
// combining branch back-pressure with ROB-full and rename-unavailable stalls.
module branch_stall_tracker #(
  parameter int ROB_TAG_W = 5,
  parameter int MAX_BR    = 4,
  parameter int MODE      = 1
) (
  input logic           clk,
  input logic           reset,
  branch_stall_if.slave bus
);
  localparam int DEPTH = (MODE == 0) ? 1 : MAX_BR;
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(MAX_BR + 1);

  logic [ROB_TAG_W-1:0] fifo_q [DEPTH];
  logic [PTR_W-1:0]     head_q, head_d;
  logic [PTR_W-1:0]     tail_q, tail_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 err_q, err_d;

  logic                 full;
  logic                 empty;
  logic                 brCommit;
  logic                 headMatch;
  logic                 alloc;
  logic                 rel;
  logic                 mismatch;
  logic                 brStall;
  logic [ROB_TAG_W-1:0] headTag;

  // Depth need not be a power of two, so pointers wrap explicitly.
  function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) return '0;
    return p + PTR_W'(1);
  endfunction

  assign full      = (count_q == CNT_W'(DEPTH));
  assign empty     = (count_q == '0);
  assign headTag   = fifo_q[head_q];
  assign brCommit  = bus.commit_valid & bus.commited_branch_op & ~bus.flush;
  assign headMatch = ~empty & (bus.commited_branch_tag == headTag);
  assign alloc     = bus.inst_valid & bus.branch_op_incoming & ~full & ~bus.flush;
  assign rel       = brCommit & headMatch;
  assign mismatch  = brCommit & ~headMatch;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    err_d   = err_q | mismatch;
    if (bus.flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (alloc) tail_d = nextPtr(tail_q);
      if (rel)   head_d = nextPtr(head_q);
      if (alloc && !rel)      count_d = count_q + CNT_W'(1);
      else if (rel && !alloc) count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) fifo_q[i] <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      err_q   <= err_d;
      if (alloc) fifo_q[tail_q] <= bus.branch_op_incoming_tag;
    end
  end

  // Legacy mode also stalls on the arriving branch itself, with zero latency.
  always_comb begin
    if (MODE == 0) brStall = ~empty | (bus.inst_valid & bus.branch_op_incoming);
    else           brStall = full;
  end

  assign bus.stall_decode      = brStall;
  assign bus.stall_fetch       = bus.rob_full | bus.cannot_rename | brStall;
  assign bus.outstanding_count = count_q;
  assign bus.oldest_tag        = empty ? '0 : headTag;
  assign bus.tag_mismatch_err  = err_q;
endmodule
